// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen: CPU clock source for the 8-bit core.
// Produces cpu_clk as a free-running divided clock (auto mode) or as single
// manual steps (manual mode), with debounced buttons, a runtime divider and
// a latched halt. cpu_clk_en marks the sys_clk cycle in which cpu_clk rises.

module cpu_clock_gen #(
    parameter int DIV_WIDTH        = 24,
    parameter int DEBOUNCE_CYCLES  = 270000,
    parameter int STEP_HIGH_CYCLES = 1350000
) (
    input  logic                 sys_clk,
    input  logic                 rst_i,
    input  logic                 mode_btn,
    input  logic                 step_btn,
    input  logic                 halt_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 cpu_clk,
    output logic                 cpu_clk_en,
    output logic                 mode_o,
    output logic                 halted_o
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    // Manual high-phase counter only needs to reach STEP_HIGH_CYCLES-1.
    localparam int STEP_W = (STEP_HIGH_CYCLES > 1) ? $clog2(STEP_HIGH_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_HIGH_CYCLES - 1);

    // Bit positions of the two buttons inside the shared button vectors.
    localparam int MODE_IDX = 0;
    localparam int STEP_IDX = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } step_state_t;

    // Button path state (bit MODE_IDX = mode button, bit STEP_IDX = step button).
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       level_q;
    logic [1:0]       level_d_q;
    logic [1:0]       press_q;
    logic [DEB_W-1:0] deb_cnt_q [2];

    logic mode_press;
    logic step_press;

    // Clock generator state.
    logic                 mode_q;
    logic                 pend_q;
    logic                 halt_q;
    logic                 clk_q;
    logic                 en_q;
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [STEP_W-1:0]    step_cnt_q;
    step_state_t          state_q;

    // Next-state values.
    logic                 mode_next;
    logic                 pend_next;
    logic                 clk_next;
    logic                 en_next;
    logic [DIV_WIDTH-1:0] div_cnt_next;
    logic [STEP_W-1:0]    step_cnt_next;
    step_state_t          state_next;
    logic [DIV_WIDTH-1:0] div_last;
    logic                 halt_block;

    assign btn_raw    = {step_btn, mode_btn};
    assign mode_press = press_q[MODE_IDX];
    assign step_press = press_q[STEP_IDX];

    // Synchronise both buttons, debounce their levels and emit one-cycle press pulses.
    always_ff @(posedge sys_clk or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            level_d_q <= '0;
            press_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_d_q <= level_q;
            press_q   <= level_q & ~level_d_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (deb_cnt_q[i] == DEB_LAST) begin
                        level_q[i]   <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Decide the next clock level, mode, counters and manual-step state.
    always_comb begin
        mode_next     = mode_q;
        pend_next     = pend_q ^ mode_press;
        clk_next      = clk_q;
        div_cnt_next  = div_cnt_q;
        step_cnt_next = step_cnt_q;
        state_next    = state_q;
        halt_block    = halt_q | halt_i;
        div_last      = (div_i == '0) ? '0 : div_i - DIV_WIDTH'(1);

        if (pend_next && !clk_q) begin
            // A pending mode change is only applied while cpu_clk is low,
            // so a high phase is never cut short by switching modes.
            mode_next     = ~mode_q;
            pend_next     = 1'b0;
            div_cnt_next  = '0;
            step_cnt_next = '0;
            state_next    = ST_IDLE;
        end else if (!mode_q) begin
            if (div_cnt_q >= div_last) begin
                div_cnt_next = '0;
                if (clk_q) begin
                    clk_next = 1'b0;
                end else if (!halt_block) begin
                    clk_next = 1'b1;
                end
            end else begin
                div_cnt_next = div_cnt_q + DIV_WIDTH'(1);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (step_press && !halt_block) begin
                        state_next    = ST_HIGH;
                        clk_next      = 1'b1;
                        step_cnt_next = '0;
                    end
                end
                ST_HIGH: begin
                    if (step_cnt_q == STEP_LAST) begin
                        state_next    = ST_IDLE;
                        clk_next      = 1'b0;
                        step_cnt_next = '0;
                    end else begin
                        step_cnt_next = step_cnt_q + STEP_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    clk_next   = 1'b0;
                end
            endcase
        end

        en_next = clk_next & ~clk_q;
    end

    // Register the clock, its rise strobe, mode, halt latch and counters.
    always_ff @(posedge sys_clk or negedge rst_i) begin
        if (!rst_i) begin
            mode_q     <= 1'b0;
            pend_q     <= 1'b0;
            halt_q     <= 1'b0;
            clk_q      <= 1'b0;
            en_q       <= 1'b0;
            div_cnt_q  <= '0;
            step_cnt_q <= '0;
            state_q    <= ST_IDLE;
        end else begin
            mode_q     <= mode_next;
            pend_q     <= pend_next;
            halt_q     <= halt_q | halt_i;
            clk_q      <= clk_next;
            en_q       <= en_next;
            div_cnt_q  <= div_cnt_next;
            step_cnt_q <= step_cnt_next;
            state_q    <= state_next;
        end
    end

    assign cpu_clk    = clk_q;
    assign cpu_clk_en = en_q;
    assign mode_o     = mode_q;
    assign halted_o   = halt_q & ~clk_q;

endmodule

// File: doc/cpu_clock_gen.md
# cpu_clock_gen

Parametrised CPU clock generator. It sits between the board oscillator and the 8-bit CPU core. It produces `cpu_clk` either as a free-running divided clock (auto mode) or as single manual steps (manual mode), with debounced push-buttons, a runtime-programmable divider and a latched CPU halt. It also emits a one-sys-cycle `cpu_clk_en` strobe, so downstream logic can stay on `sys_clk`.

## Interface

Parameters:
- `DIV_WIDTH`, 24: width of the half-period divider input and counter.
- `DEBOUNCE_CYCLES`, 270000: number of consecutive stable `sys_clk` cycles before a button level is accepted. Must be ≥1.
- `STEP_HIGH_CYCLES`, 1350000: duration of the `cpu_clk` high phase for a manual step, in `sys_clk` cycles. Must be ≥1.

Ports:
- `sys_clk`, input, 1: system clock; the only clock.
- `rst_i`, input, 1: reset, asynchronous assert, active-low.
- `mode_btn`, input, 1: raw mode button, active-high, asynchronous to `sys_clk`. Each accepted press toggles the mode.
- `step_btn`, input, 1: raw step button, active-high, asynchronous. Each accepted press requests one manual cycle.
- `halt_i`, input, 1: CPU HLT, synchronous to `sys_clk`, level.
- `div_i`, input, DIV_WIDTH: auto-mode half-period in `sys_clk` cycles. 0 is treated as 1.
- `cpu_clk`, output, 1: generated CPU clock, registered.
- `cpu_clk_en`, output, 1: high for exactly the `sys_clk` cycle in which `cpu_clk` first reads 1.
- `mode_o`, output, 1: 0 = auto, 1 = manual.
- `halted_o`, output, 1: halt latched and `cpu_clk` parked low.

## Operation

Reset values (`rst_i`=0): `cpu_clk`=0, `cpu_clk_en`=0, `mode_o`=0, `halted_o`=0. The divider counter, debouncers, pending-toggle and halt latch are all cleared.

Button path (identical for each button):
- 2-FF synchroniser feeds a debounce counter.
- The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- A 0→1 transition of the debounced level gives a one-cycle press pulse.
- Release needs no action beyond debouncing.

Mode control:
- A mode press sets `toggle_pending`.
- The pending toggle is applied on the first cycle where `cpu_clk`=0, which may be the same cycle as the press. Applying it flips `mode_o`, clears the divider counter and clears `toggle_pending`.
- A second press while a toggle is pending cancels it, so the pending flag itself toggles.
- `cpu_clk` high phases are never truncated by a mode change.

Auto mode, with `D` = max(`div_i`, 1):
- Counter increments each cycle.
- When counter ≥ D−1, `cpu_clk` toggles and the counter clears. Using ≥ means a shrinking `div_i` takes effect immediately without wrap.
- Step presses are ignored.

Manual mode, states IDLE and HIGH:
- IDLE: `cpu_clk`=0. A step press moves to HIGH, sets `cpu_clk`=1 and clears the counter.
- HIGH: counter increments. When counter = STEP_HIGH_CYCLES−1, go to IDLE with `cpu_clk`=0.
- Step presses in HIGH are dropped, not queued.

Halt:
- `halt_i`=1 on any cycle sets the halt latch. Only reset clears it.
- While latched, `cpu_clk` performs no further 0→1 transition.
- A high phase in progress completes at its normal length (D in auto, STEP_HIGH_CYCLES in manual), then `cpu_clk` stays 0.
- `halted_o` = latch & (`cpu_clk`=0).
- Mode presses still toggle `mode_o` while halted.

Strobe: `cpu_clk_en` = `cpu_clk` & ~`cpu_clk` delayed by 1 cycle. It is registered alongside `cpu_clk`, so both are high in the same cycle.

## Timing

- Auto: period is 2·D cycles at 50 % duty. After reset release with `div_i`=D, `cpu_clk` first reads 1 on cycle D, counting the first edge after release as cycle 1.
- `div_i` change: takes effect at the next comparison; no glitch shorter than 1 cycle is possible.
- Button latency: a clean press seen at `mode_btn`/`step_btn` produces a press pulse 2 + DEBOUNCE_CYCLES + 1 cycles later.
- Manual: `cpu_clk` rises the cycle after the step press pulse and stays high for exactly STEP_HIGH_CYCLES cycles.
- Reset mid-high-phase: `cpu_clk` drops to 0 asynchronously. This is the only case where a high phase is truncated.
- `halted_o` rises the cycle after `cpu_clk` falls, or the cycle after `halt_i` if `cpu_clk` was already 0.

## Test plan

Sim parameters: DEBOUNCE_CYCLES=4, STEP_HIGH_CYCLES=3, DIV_WIDTH=8.

1. Auto, `div_i`=5, after reset → `cpu_clk` high on cycles 5–9, low on 10–14, period 10. `cpu_clk_en` pulses only on cycles 5, 15, 25.
2. `div_i`=0 → `cpu_clk` toggles every cycle (period 2). Change `div_i` from 20 to 3 while the counter is at 10 → toggle on the next cycle, then half-period 3.
3. Mode press with a bounce (1,0,1 then held) → exactly one toggle after the held level has been stable 4 cycles. If pressed while `cpu_clk`=1, `mode_o` flips only once `cpu_clk`=0.
4. Manual: two step presses 20 cycles apart → two high pulses of exactly 3 cycles each and two `cpu_clk_en` pulses. A press during HIGH → no extra pulse.
5. Auto, `div_i`=5, `halt_i` pulsed 1 cycle mid-high phase → high phase still lasts 5 cycles, then `cpu_clk`=0 permanently and `halted_o`=1. A step press or mode toggle → no `cpu_clk` edge.
6. `rst_i` asserted mid-HIGH → all outputs 0 immediately. After release, the block is in auto mode and the first rise comes at cycle D.
